// File: rtl/lpm_port_resolve.sv
// lpm_port_resolve: buffers each packet, resolves its first word against the external LPM table
//   (one request, bounded wait), rewrites the TUSER destination or applies the miss policy, and
//   keeps saturating hit/miss/drop/timeout counters.
// Latency: pass-through 1 cycle from FIFO head to M_AXIS_TVALID; routed path 2 cycles minimum.
// Backpressure: S_AXIS_TREADY drops when the input FIFO is nearly full; M_AXIS_TREADY low holds the head.
// Ports: S_AXIS_* slave stream in, M_AXIS_* master stream out (only TUSER modified), lkp_* LPM
//   request/response, arp_lookup/nh_reg/oq_reg per-packet decision for the ARP stage, *_count stats.
module lpm_port_resolve #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int NUM_PORTS            = 4,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24,
  parameter int MISS_MODE            = 0,
  parameter int LKP_TIMEOUT          = 15,
  parameter int FIFO_DEPTH_BITS      = 2
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,
  output logic                              lkp_req,
  input  logic                              lkp_valid,
  input  logic                              lkp_hit,
  input  logic [31:0]                       lkp_nh,
  input  logic [7:0]                        lkp_oq,
  input  logic                              counter_clear,
  output logic                              arp_lookup,
  output logic [31:0]                       nh_reg,
  output logic [7:0]                        oq_reg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     hit_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     miss_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     drop_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     timeout_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int PW    = 2 * NUM_PORTS;
  localparam int SW    = C_S_AXIS_DATA_WIDTH / 8;
  localparam int EW    = C_S_AXIS_DATA_WIDTH + SW + C_S_AXIS_TUSER_WIDTH + 1;
  localparam int TW    = $clog2(LKP_TIMEOUT + 1);
  localparam int CW    = C_S_AXI_DATA_WIDTH;
  // Odd bits of a port field are the CPU queues.
  localparam logic [PW-1:0] CPU_MASK = {NUM_PORTS{2'b10}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT_LKP, S_FWD, S_DROP} state_t;

  // ---------------- input FIFO ----------------
  logic [EW-1:0]              fifo_mem_q [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   fifo_cnt_q, fifo_cnt_d;
  logic                       fifo_empty, fifo_nearly_full, push, pop;
  logic [EW-1:0]              head;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  head_tdata;
  logic [SW-1:0]                   head_tstrb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] head_tuser;
  logic                            head_last;
  logic [PW-1:0]                   head_dst;

  assign fifo_empty       = (fifo_cnt_q == '0);
  assign fifo_nearly_full = (fifo_cnt_q >= (FIFO_DEPTH_BITS+1)'(DEPTH - 1));
  // Held low through reset so nothing is accepted into a FIFO that is being flushed.
  assign S_AXIS_TREADY    = !AXI_RESET && !fifo_nearly_full;
  assign push             = S_AXIS_TVALID && S_AXIS_TREADY;

  assign head = fifo_mem_q[rd_ptr_q];
  assign {head_tdata, head_tstrb, head_tuser, head_last} = head;
  assign head_dst = head_tuser[DST_PORT_POS +: PW];

  always_ff @(posedge AXI_ACLK) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (pop && !push) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  // ---------------- decision FSM ----------------
  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            lkp_req_q, lkp_req_d;
  logic [PW-1:0]   dst_q, dst_d;
  logic            first_q, first_d;
  logic            arp_q, arp_d;
  logic [31:0]     nh_q, nh_d;
  logic [7:0]      oq_q, oq_d;
  logic            hit_inc, miss_inc, drop_inc, to_inc, miss;
  logic            oq_ok, src_found;
  logic [PW-1:0]   src_cpu, hit_dst;
  logic [CW-1:0]   hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d, to_cnt_q, to_cnt_d;

  assign oq_ok   = ({24'd0, lkp_oq} < 32'(NUM_PORTS));
  assign hit_dst = PW'(1) << {lkp_oq, 1'b0};

  // Punt target: CPU queue of the lowest-numbered source MAC port (descending loop, lowest wins).
  always_comb begin
    src_found = 1'b0;
    src_cpu   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (head_tuser[SRC_PORT_POS + 2*i]) begin
        src_found        = 1'b1;
        src_cpu          = '0;
        src_cpu[2*i + 1] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    lkp_req_d = 1'b0;
    dst_d     = dst_q;
    first_d   = first_q;
    arp_d     = arp_q;
    nh_d      = nh_q;
    oq_d      = oq_q;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    drop_inc  = 1'b0;
    to_inc    = 1'b0;
    miss      = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (|(head_dst & CPU_MASK)) begin
            // Destination already names a CPU queue: forward untouched.
            dst_d   = head_dst;
            first_d = 1'b1;
            state_d = S_FWD;
          end else begin
            lkp_req_d = 1'b1;
            timer_d   = '0;
            state_d   = S_WAIT_LKP;
          end
        end
      end
      S_WAIT_LKP: begin
        timer_d = timer_q + 1'b1;
        if (lkp_valid) begin
          if (lkp_hit && oq_ok) begin
            dst_d   = hit_dst;
            nh_d    = lkp_nh;
            oq_d    = lkp_oq;
            arp_d   = 1'b1;
            first_d = 1'b1;
            hit_inc = 1'b1;
            state_d = S_FWD;
          end else begin
            miss = 1'b1;
          end
        end else if (timer_q == TW'(LKP_TIMEOUT)) begin
          to_inc = 1'b1;
          miss   = 1'b1;
        end
        if (miss) begin
          miss_inc = 1'b1;
          if (MISS_MODE == 0 && src_found) begin
            dst_d   = src_cpu;
            first_d = 1'b1;
            state_d = S_FWD;
          end else begin
            drop_inc = 1'b1;
            state_d  = S_DROP;
          end
        end
      end
      S_FWD: begin
        pop = !fifo_empty && M_AXIS_TREADY;
        if (pop) begin
          first_d = 1'b0;
          if (head_last) begin
            arp_d   = 1'b0;
            nh_d    = '0;
            oq_d    = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        pop = !fifo_empty;
        if (pop && head_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear wins over a same-cycle increment; increments stop at all-ones.
  function automatic logic [CW-1:0] bump(input logic [CW-1:0] c, input logic inc, input logic clr);
    if (clr) return '0;
    if (inc && (c != '1)) return c + 1'b1;
    return c;
  endfunction

  always_comb begin
    hit_cnt_d  = bump(hit_cnt_q,  hit_inc,  counter_clear);
    miss_cnt_d = bump(miss_cnt_q, miss_inc, counter_clear);
    drop_cnt_d = bump(drop_cnt_q, drop_inc, counter_clear);
    to_cnt_d   = bump(to_cnt_q,   to_inc,   counter_clear);
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      lkp_req_q  <= 1'b0;
      dst_q      <= '0;
      first_q    <= 1'b0;
      arp_q      <= 1'b0;
      nh_q       <= '0;
      oq_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      drop_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      lkp_req_q  <= lkp_req_d;
      dst_q      <= dst_d;
      first_q    <= first_d;
      arp_q      <= arp_d;
      nh_q       <= nh_d;
      oq_q       <= oq_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // ---------------- outputs ----------------
  assign M_AXIS_TVALID = (state_q == S_FWD) && !fifo_empty;

  // Stream outputs read zero while the FIFO is empty; the decided destination goes on the first beat only.
  always_comb begin
    M_AXIS_TDATA = '0;
    M_AXIS_TSTRB = '0;
    M_AXIS_TUSER = '0;
    M_AXIS_TLAST = 1'b0;
    if (!fifo_empty) begin
      M_AXIS_TDATA = head_tdata;
      M_AXIS_TSTRB = head_tstrb;
      M_AXIS_TUSER = head_tuser;
      M_AXIS_TLAST = head_last;
      if (first_q) M_AXIS_TUSER[DST_PORT_POS +: PW] = dst_q;
    end
  end

  assign lkp_req       = lkp_req_q;
  assign arp_lookup    = arp_q;
  assign nh_reg        = nh_q;
  assign oq_reg        = oq_q;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;
  assign drop_count    = drop_cnt_q;
  assign timeout_count = to_cnt_q;

endmodule
